// File: rtl/addsub_pkg.sv
// Shared types and helpers for the sequential add/subtract unit.
// Holds the control states, opcode encodings and the chunk-index width.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_addc_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
// Shared by every slice of the multi-cycle add/subtract.
module addc_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_s,
    output logic             o_cout
);

    assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b}
                         + {{CHUNK{1'b0}}, i_cin};

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract, one CHUNK-bit slice per clock.
// Valid/ready on both sides; reports carry-out and signed overflow.
import addsub_pkg::*;

module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             OP,
    input  logic             CIN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             OVF
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_o;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [IW-1:0]    r_idx;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_lsb;
    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;
    logic [CHUNK-1:0] w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_lsb  = 32'(r_idx) * CHUNK;
    assign w_sa   = r_a[w_lsb +: CHUNK];
    assign w_sb   = r_b[w_lsb +: CHUNK];
    assign w_last = (r_idx == IW'(NCHUNK - 1));

    addc_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[w_lsb +: CHUNK] = w_s;
    end

    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        OUT_VALID   = 1'b0;
        unique case (r_state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                OUT_VALID = 1'b1;
                IN_READY  = OUT_READY;
                if (OUT_READY)
                    w_state_nxt = IN_VALID ? RUN : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = IN_VALID && IN_READY;

    always_ff @(posedge CLK) begin
        if (!RESETN) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Result registers only update on the final slice, so O never shows
    // a partially computed value.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_o     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= I0;
            r_b     <= (OP == OP_SUB) ? ~I1 : I1;
            r_carry <= (OP == OP_SUB) ? ~CIN : CIN;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_nxt;
            r_carry <= w_c;
            r_idx   <= r_idx + IW'(1);
            if (w_last) begin
                r_o    <= w_acc_nxt;
                r_cout <= w_c;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                       && (w_acc_nxt[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign O    = r_o;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule
